// File: rtl/run_read_issuer.sv
// Issues round-robin AXI read bursts for several leaf channels and tracks the returning beats
// so it can mark sub-run boundaries and signal when the whole run has drained.
module run_read_issuer #(
    parameter int NUM_READ_CHANNELS  = 4,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 64,
    parameter int C_BURST_SIZE_BYTES = 1024,
    localparam int CH_W = $clog2(NUM_READ_CHANNELS)
) (
    input  logic                                                aclk,
    input  logic                                                ap_rst_n,
    input  logic                                                read_start,
    input  logic [NUM_READ_CHANNELS-1:0][C_M_AXI_ADDR_WIDTH-1:0] read_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                        read_size_in_bytes,
    input  logic                                                read_divide,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                        read_run_count,
    output logic                                                single_run_read_done,
    output logic                                                busy,
    output logic                                                m_arvalid,
    input  logic                                                m_arready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                       m_araddr,
    output logic [7:0]                                          m_arlen,
    output logic [CH_W-1:0]                                     m_arid,
    input  logic                                                m_rvalid,
    output logic                                                m_rready,
    input  logic [CH_W-1:0]                                     m_rid,
    input  logic                                                m_rlast,
    output logic [NUM_READ_CHANNELS-1:0]                        run_boundary
);

    localparam int N  = NUM_READ_CHANNELS;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int XW = C_XFER_SIZE_WIDTH;
    localparam logic [XW-1:0] BURST = XW'(C_BURST_SIZE_BYTES);
    localparam logic [XW-1:0] ONE   = XW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic [N-1:0][AW-1:0]   addr;
    logic [N-1:0][XW-1:0]   remaining;
    logic [N-1:0][XW-1:0]   beat_cnt;
    logic [N-1:0][XW-1:0]   sub_cnt;
    logic [XW-1:0]          expected;
    logic [XW-1:0]          run_count;
    logic [XW-1:0]          outstanding;
    logic [XW-1:0]          burst_len;
    logic                   divide;
    logic [CH_W-1:0]        cur_ch;

    logic                   sel_found;
    logic [CH_W-1:0]        sel_ch;
    logic [XW-1:0]          sel_len;
    logic                   all_beats;
    logic                   ar_hs;
    logic                   r_hs;
    logic                   rl_hs;

    assign ar_hs = m_arvalid && m_arready;
    assign r_hs  = m_rvalid && m_rready;
    assign rl_hs = r_hs && m_rlast;
    assign busy  = (state != IDLE);

    // Round-robin search from cur_ch; descending loop so the nearest non-empty channel wins.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx       = '0;
        sel_found = 1'b0;
        sel_ch    = cur_ch;
        for (int i = N - 1; i >= 0; i--) begin
            idx = cur_ch + CH_W'(i);
            if (remaining[idx] != '0) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
        sel_len   = (remaining[sel_ch] < BURST) ? remaining[sel_ch] : BURST;
        all_beats = 1'b1;
        for (int c = 0; c < N; c++) begin
            if (beat_cnt[c] != expected) all_beats = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state                <= IDLE;
            addr                 <= '0;
            remaining            <= '0;
            beat_cnt             <= '0;
            sub_cnt              <= '0;
            expected             <= '0;
            run_count            <= '0;
            outstanding          <= '0;
            burst_len            <= '0;
            divide               <= 1'b0;
            cur_ch               <= '0;
            m_arvalid            <= 1'b0;
            m_araddr             <= '0;
            m_arlen              <= '0;
            m_arid               <= '0;
            m_rready             <= 1'b0;
            single_run_read_done <= 1'b0;
            run_boundary         <= '0;
        end else begin
            single_run_read_done <= 1'b0;
            run_boundary         <= '0;

            if (r_hs) begin
                beat_cnt[m_rid] <= beat_cnt[m_rid] + ONE;
                if (divide) begin
                    if (sub_cnt[m_rid] + ONE == run_count) begin
                        sub_cnt[m_rid]      <= '0;
                        run_boundary[m_rid] <= 1'b1;
                    end else begin
                        sub_cnt[m_rid] <= sub_cnt[m_rid] + ONE;
                    end
                end else if (beat_cnt[m_rid] + ONE == expected) begin
                    run_boundary[m_rid] <= 1'b1;
                end
            end

            // A simultaneous AR handshake and rlast beat cancel out.
            if (ar_hs && !rl_hs) begin
                outstanding <= outstanding + ONE;
            end else if (!ar_hs && rl_hs) begin
                outstanding <= outstanding - ONE;
            end

            case (state)
                IDLE: begin
                    if (read_start) begin
                        addr        <= read_addr;
                        remaining   <= {N{read_size_in_bytes}};
                        expected    <= read_size_in_bytes >> 6;
                        divide      <= read_divide;
                        run_count   <= (read_run_count == '0) ? ONE : read_run_count;
                        beat_cnt    <= '0;
                        sub_cnt     <= '0;
                        outstanding <= '0;
                        cur_ch      <= '0;
                        if (read_size_in_bytes == '0) begin
                            state <= DONE;
                        end else begin
                            state    <= ISSUE;
                            m_rready <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    // AR fields are only reloaded while arvalid is low, so they hold during stalls.
                    if (m_arvalid) begin
                        if (m_arready) begin
                            m_arvalid         <= 1'b0;
                            addr[m_arid]      <= addr[m_arid] + AW'(burst_len);
                            remaining[m_arid] <= remaining[m_arid] - burst_len;
                            cur_ch            <= m_arid + CH_W'(1);
                        end
                    end else if (sel_found) begin
                        m_arvalid <= 1'b1;
                        m_araddr  <= addr[sel_ch];
                        m_arlen   <= 8'((sel_len >> 6) - ONE);
                        m_arid    <= sel_ch;
                        burst_len <= sel_len;
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (all_beats && outstanding == '0) begin
                        state    <= DONE;
                        m_rready <= 1'b0;
                    end
                end
                DONE: begin
                    single_run_read_done <= 1'b1;
                    state                <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
